// File: rtl/set_btn_ctrl.sv
// Hours/minutes set-button controller.
// Synchronises and debounces the raw set buttons, then turns a press or hold
// into single-cycle increment pulses: one on press, SLOW_REPEATS repeats at
// the slow set rate, then repeats at the fast set rate until release.
// Holding both buttons locks both channels out until each is released.
module set_btn_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned SLOW_REPEATS = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_debounce_stb,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_btn_hours,
  input  logic i_btn_minutes,
  output logic o_hours_inc,
  output logic o_minutes_inc,
  output logic o_set_active
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CNT) + 1;
  localparam int unsigned RepBits = $clog2(SLOW_REPEATS + 1);
  localparam int unsigned RepW    = (RepBits > 0) ? RepBits : 1;

  typedef enum logic [1:0] {StIdle, StSlow, StFast, StLock} state_e;

  // Index 0 is the hours channel, index 1 the minutes channel.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q;
  logic [DbW-1:0] deb_cnt_q [2];

  state_e         state_q [2];
  state_e         state_d [2];
  logic [RepW-1:0] rep_q [2];
  logic [RepW-1:0] rep_d [2];
  logic [1:0]     inc_q, inc_d;
  logic           active_q, active_d;
  logic           both_held;

  assign btn_raw = {i_btn_minutes, i_btn_hours};

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CNT consecutive differing strobe samples.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      deb_q <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else if (i_debounce_stb) begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DbW'(DEBOUNCE_CNT - 1)) begin
          deb_q[i]     <= ~deb_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign both_held = &deb_q;

  // Per-channel press/repeat FSM next state and pulse decision.
  always_comb begin
    active_d = 1'b0;
    inc_d    = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      rep_d[i]   = rep_q[i];
      if (both_held) begin
        // Lockout overrides everything, including a pulse due this cycle.
        state_d[i] = StLock;
        rep_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (deb_q[i]) begin
              state_d[i] = StSlow;
              rep_d[i]   = '0;
              inc_d[i]   = 1'b1;
            end
          end
          StSlow: begin
            // A release wins over a coincident strobe.
            if (!deb_q[i]) begin
              state_d[i] = StIdle;
            end else if (i_slow_set_stb) begin
              inc_d[i] = 1'b1;
              rep_d[i] = rep_q[i] + 1'b1;
              if (rep_q[i] == RepW'(SLOW_REPEATS - 1)) begin
                state_d[i] = StFast;
              end
            end
          end
          StFast: begin
            if (!deb_q[i]) begin
              state_d[i] = StIdle;
            end else if (i_fast_set_stb) begin
              inc_d[i] = 1'b1;
            end
          end
          StLock: begin
            if (!deb_q[i]) begin
              state_d[i] = StIdle;
            end
          end
          default: begin
            state_d[i] = StIdle;
          end
        endcase
      end
      if (state_d[i] == StSlow || state_d[i] == StFast) begin
        active_d = 1'b1;
      end
    end
  end

  // FSM state, repeat counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdle;
        rep_q[i]   <= '0;
      end
      inc_q    <= '0;
      active_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        rep_q[i]   <= rep_d[i];
      end
      inc_q    <= inc_d;
      active_q <= active_d;
    end
  end

  assign o_hours_inc   = inc_q[0];
  assign o_minutes_inc = inc_q[1];
  assign o_set_active  = active_q;

endmodule

// File: tb/tb_set_btn_ctrl.sv
// Self-checking bench for set_btn_ctrl: directed scenarios plus randomized
// hold sequences checked against a pulse-count reference model.
module tb_set_btn_ctrl;

  localparam int DB = 8;
  localparam int SR = 4;

  logic clk = 1'b0;
  logic rst_n, deb_stb, slow_stb, fast_stb, btn_h, btn_m;
  logic hours_inc, minutes_inc, set_active;

  int errors = 0;
  int checks = 0;
  int h_cnt = 0, m_cnt = 0, width_err = 0;
  logic h_prev = 1'b0, m_prev = 1'b0;

  set_btn_ctrl #(
    .DEBOUNCE_CNT(DB),
    .SLOW_REPEATS(SR)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_debounce_stb(deb_stb),
    .i_slow_set_stb(slow_stb),
    .i_fast_set_stb(fast_stb),
    .i_btn_hours   (btn_h),
    .i_btn_minutes (btn_m),
    .o_hours_inc   (hours_inc),
    .o_minutes_inc (minutes_inc),
    .o_set_active  (set_active)
  );

  always #5 clk = ~clk;

  // Pulse counters and width monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (hours_inc === 1'b1) h_cnt <= h_cnt + 1;
    if (minutes_inc === 1'b1) m_cnt <= m_cnt + 1;
    if ((hours_inc === 1'b1 && h_prev === 1'b1) || (minutes_inc === 1'b1 && m_prev === 1'b1))
      width_err <= width_err + 1;
    h_prev <= hours_inc;
    m_prev <= minutes_inc;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic h, input logic m);
    btn_h = h;
    btn_m = m;
    tick(3);
  endtask

  task automatic dstb(input int n);
    repeat (n) begin
      deb_stb = 1'b1;
      tick(1);
      deb_stb = 1'b0;
      tick(3);
    end
  endtask

  task automatic sstb();
    slow_stb = 1'b1;
    tick(1);
    slow_stb = 1'b0;
    tick(3);
  endtask

  task automatic fstb();
    fast_stb = 1'b1;
    tick(1);
    fast_stb = 1'b0;
    tick(3);
  endtask

  int exp_h, exp_m, b, len, kind, slow_seen, base, p, nseg;
  bit fast_mode;

  initial begin
    exp_h = 0;
    exp_m = 0;
    rst_n = 1'b0;
    deb_stb = 1'b0;
    slow_stb = 1'b0;
    fast_stb = 1'b0;
    btn_h = 1'b0;
    btn_m = 1'b0;
    tick(3);
    check("reset_hours_inc", 32'(hours_inc), 0);
    check("reset_minutes_inc", 32'(minutes_inc), 0);
    check("reset_set_active", 32'(set_active), 0);
    rst_n = 1'b1;
    tick(2);

    // Idle: buttons low, no pulses regardless of strobes.
    dstb(1000);
    sstb();
    fstb();
    check("idle_hours", h_cnt, exp_h);
    check("idle_minutes", m_cnt, exp_m);

    // Glitch shorter than the debounce window.
    set_btns(1'b1, 1'b0);
    dstb(5);
    set_btns(1'b0, 1'b0);
    dstb(DB);
    check("glitch5_hours", h_cnt, exp_h);
    set_btns(1'b1, 1'b0);
    dstb($urandom_range(1, DB - 1));
    set_btns(1'b0, 1'b0);
    dstb(DB);
    check("glitch_rand_hours", h_cnt, exp_h);
    check("glitch_active", 32'(set_active), 0);

    // Single press: pulse exactly on the DB-th accepted sample.
    set_btns(1'b1, 1'b0);
    dstb(DB - 1);
    check("press_early_hours", h_cnt, exp_h);
    dstb(1);
    exp_h++;
    check("press_hours", h_cnt, exp_h);
    dstb(20 - DB);
    check("press_held_hours", h_cnt, exp_h);
    check("press_active", 32'(set_active), 1);
    set_btns(1'b0, 1'b0);
    dstb(DB);
    check("press_release_hours", h_cnt, exp_h);
    check("press_release_active", 32'(set_active), 0);

    // Auto-repeat: 6 slow then 4 fast strobes -> 9 pulses total.
    base = m_cnt;
    set_btns(1'b0, 1'b1);
    dstb(DB);
    repeat (6) begin
      sstb();
      check("autorep_active_slow", 32'(set_active), 1);
    end
    check("autorep_after_slow", m_cnt - base, 5);
    repeat (4) begin
      fstb();
      check("autorep_active_fast", 32'(set_active), 1);
    end
    check("autorep_total", m_cnt - base, 9);
    set_btns(1'b0, 1'b0);
    dstb(DB);
    exp_m = m_cnt - base + exp_m;
    exp_m = base + 9;
    check("autorep_release", m_cnt, exp_m);
    check("autorep_release_active", 32'(set_active), 0);

    // Release coincident with a slow strobe: fall wins.
    set_btns(1'b0, 1'b1);
    dstb(DB);
    exp_m++;
    sstb();
    exp_m++;
    check("collide_setup", m_cnt, exp_m);
    set_btns(1'b0, 1'b0);
    dstb(DB - 1);
    deb_stb = 1'b1;
    tick(1);
    deb_stb = 1'b0;
    slow_stb = 1'b1;
    tick(1);
    slow_stb = 1'b0;
    tick(3);
    check("collide_minutes", m_cnt, exp_m);
    check("collide_active", 32'(set_active), 0);
    sstb();
    check("collide_idle_minutes", m_cnt, exp_m);

    // Lockout.
    set_btns(1'b1, 1'b0);
    dstb(DB);
    exp_h++;
    check("lock_first_hours", h_cnt, exp_h);
    set_btns(1'b1, 1'b1);
    dstb(DB);
    sstb();
    fstb();
    check("lock_hours", h_cnt, exp_h);
    check("lock_minutes", m_cnt, exp_m);
    check("lock_active", 32'(set_active), 0);
    set_btns(1'b1, 1'b0);
    dstb(DB);
    sstb();
    sstb();
    fstb();
    check("lock_half_hours", h_cnt, exp_h);
    check("lock_half_minutes", m_cnt, exp_m);
    check("lock_half_active", 32'(set_active), 0);
    set_btns(1'b0, 1'b0);
    dstb(DB);
    set_btns(1'b1, 1'b0);
    dstb(DB);
    exp_h++;
    check("lock_repress_hours", h_cnt, exp_h);
    set_btns(1'b0, 1'b0);
    dstb(DB);

    // Simultaneous rise: both lock, no pulse.
    set_btns(1'b1, 1'b1);
    dstb(DB);
    sstb();
    check("both_hours", h_cnt, exp_h);
    check("both_minutes", m_cnt, exp_m);
    check("both_active", 32'(set_active), 0);
    set_btns(1'b0, 1'b0);
    dstb(DB);
    set_btns(1'b0, 1'b1);
    dstb(DB);
    exp_m++;
    check("both_repress_minutes", m_cnt, exp_m);
    set_btns(1'b0, 1'b0);
    dstb(DB);

    // Bounce: toggle with a period under the debounce window, then settle high.
    p = $urandom_range(1, DB - 1);
    nseg = 2 * $urandom_range(4, 8);
    for (int s = 0; s < nseg; s++) begin
      set_btns((s % 2) == 0, 1'b0);
      dstb(p);
    end
    check("bounce_toggle_hours", h_cnt, exp_h);
    set_btns(1'b1, 1'b0);
    dstb(DB - 1);
    check("bounce_early_hours", h_cnt, exp_h);
    dstb(1);
    exp_h++;
    check("bounce_hours", h_cnt, exp_h);
    set_btns(1'b0, 1'b0);
    dstb(DB);

    // Reset mid-hold, asserted while a repeat pulse is high.
    set_btns(1'b1, 1'b0);
    dstb(DB);
    exp_h++;
    slow_stb = 1'b1;
    @(posedge clk);
    #2;
    slow_stb = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_hours_inc", 32'(hours_inc), 0);
    check("midrst_active", 32'(set_active), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    dstb(DB - 1);
    check("midrst_redebounce_hours", h_cnt, exp_h);
    dstb(1);
    exp_h++;
    check("midrst_repress_hours", h_cnt, exp_h);
    check("midrst_active_again", 32'(set_active), 1);
    set_btns(1'b0, 1'b0);
    dstb(DB);

    // Randomized holds against the repeat-rate model.
    for (int it = 0; it < 6; it++) begin
      b = $urandom_range(0, 1);
      len = $urandom_range(0, 12);
      set_btns(b == 0, b == 1);
      dstb(DB);
      if (b == 0) exp_h++;
      else exp_m++;
      slow_seen = 0;
      fast_mode = 1'b0;
      for (int k = 0; k < len; k++) begin
        kind = $urandom_range(0, 1);
        if (kind == 0) sstb();
        else fstb();
        if (kind == 0 && !fast_mode) begin
          slow_seen++;
          if (b == 0) exp_h++;
          else exp_m++;
          if (slow_seen == SR) fast_mode = 1'b1;
        end else if (kind == 1 && fast_mode) begin
          if (b == 0) exp_h++;
          else exp_m++;
        end
        check("rand_hours", h_cnt, exp_h);
        check("rand_minutes", m_cnt, exp_m);
        check("rand_active", 32'(set_active), 1);
      end
      set_btns(1'b0, 1'b0);
      dstb(DB);
      check("rand_release_hours", h_cnt, exp_h);
      check("rand_release_minutes", m_cnt, exp_m);
      check("rand_release_active", 32'(set_active), 0);
    end

    check("pulse_width", width_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
